// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 32-bit ripple adder among
// NREQ requesters, with a one-entry registered response slot tagged by id.

module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[32];

endmodule

module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic [15:0]          op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           slot_free;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;
    logic           accept;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_cin;
    logic           sel_sub;
    logic [31:0]    b_eff;
    logic           c_eff;
    logic [31:0]    sum_next;
    logic           cout_next;
    logic           ovf_next;
    logic [IDW-1:0] ptr_next;

    // The slot can take a new result if it is empty or being drained this cycle
    assign slot_free = (state == EMPTY) | rsp_ready;
    assign rsp_valid = (state == FULL);

    // Round-robin search starting at ptr for the first valid requester
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NREQ)) begin
                cand = cand - (IDW + 1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    // One-hot grant, suppressed during reset or when the slot cannot accept
    always_comb begin
        req_ready = '0;
        if (!rst && slot_free && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = |req_ready;

    assign sel_a    = req_a[{grant_id, 5'b0} +: 32];
    assign sel_b    = req_b[{grant_id, 5'b0} +: 32];
    assign sel_cin  = req_cin[grant_id];
    assign sel_sub  = req_sub[grant_id];
    assign b_eff    = sel_sub ? ~sel_b : sel_b;
    assign c_eff    = sel_sub ? 1'b1 : sel_cin;
    assign ovf_next = (sel_a[31] == b_eff[31]) && (sum_next[31] != sel_a[31]);
    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    adder_32bit u_adder (
        .a    (sel_a),
        .b    (b_eff),
        .cin  (c_eff),
        .sum  (sum_next),
        .cout (cout_next)
    );

    // Slot FSM: capture the granted result, advance the pointer, count accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            op_count <= '0;
        end else if (accept) begin
            state    <= FULL;
            ptr      <= ptr_next;
            rsp_id   <= grant_id;
            rsp_sum  <= sum_next;
            rsp_cout <= cout_next;
            rsp_ovf  <= ovf_next;
            op_count <= op_count + 16'd1;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: randomized and directed stimulus against a
// behavioural round-robin/arithmetic model, checked through a response queue.

module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 rsp_ovf;
    logic [15:0]          op_count;

    logic                 pend_valid [NREQ];
    logic [31:0]          pend_a     [NREQ];
    logic [31:0]          pend_b     [NREQ];
    logic                 pend_cin   [NREQ];
    logic                 pend_sub   [NREQ];

    bit                   model_full;
    int                   model_ptr;
    logic [15:0]          model_count;
    int                   last_grant;
    rsp_t                 exp_q [$];

    int                   check_count;
    int                   pass_count;

    adder_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .op_count  (op_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic: plain wide unsigned and signed sums
    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                            output logic [31:0] s, output logic co, output logic ov);
        logic [31:0] bb;
        logic        c;
        logic [32:0] wide;
        longint      r;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        wide = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        s    = wide[31:0];
        co   = wide[32];
        r    = longint'($signed(a)) + longint'($signed(bb)) + longint'(c);
        ov   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic load_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        pend_valid[i] = 1'b1;
        pend_a[i]     = a;
        pend_b[i]     = b;
        pend_cin[i]   = cin;
        pend_sub[i]   = sub;
    endtask

    task automatic load_random(input int i);
        load_req(i, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic refill_all();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_valid[i]) load_random(i);
        end
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend_valid[i];
            req_a[32*i +: 32]   = pend_a[i];
            req_b[32*i +: 32]   = pend_b[i];
            req_cin[i]          = pend_cin[i];
            req_sub[i]          = pend_sub[i];
        end
    endtask

    // Advance to the next falling edge and retire whichever request was accepted
    task automatic next_cycle();
        @(negedge clk);
        if (last_grant >= 0) pend_valid[last_grant] = 1'b0;
    endtask

    task automatic clear_pend();
        for (int i = 0; i < NREQ; i++) begin
            pend_valid[i] = 1'b0;
            pend_a[i]     = '0;
            pend_b[i]     = '0;
            pend_cin[i]   = 1'b0;
            pend_sub[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_pend();
        apply_stimulus();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply_stimulus();
    endtask

    // Reference model: predicts grant, slot occupancy and count; queues expected results
    always begin
        int g;
        @(negedge clk);
        #4;
        if (rst) begin
            model_full  = 1'b0;
            model_ptr   = 0;
            model_count = '0;
            last_grant  = -1;
            exp_q.delete();
        end else begin
            rsp_t        e;
            logic [31:0] s;
            logic        co;
            logic        ov;
            logic [NREQ-1:0] exp_ready;
            check_output("rsp_valid_state", 64'(rsp_valid), 64'(model_full));
            check_output("op_count", 64'(op_count), 64'(model_count));
            g = -1;
            if (!model_full || rsp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pend_valid[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check_output("req_ready", 64'(req_ready), 64'(exp_ready));
            if (g >= 0) begin
                model_op(pend_a[g], pend_b[g], pend_cin[g], pend_sub[g], s, co, ov);
                e.id   = g;
                e.sum  = s;
                e.cout = co;
                e.ovf  = ov;
                exp_q.push_back(e);
                model_ptr   = (g + 1) % NREQ;
                model_count = model_count + 16'd1;
                model_full  = 1'b1;
            end else if (rsp_ready) begin
                model_full = 1'b0;
            end
            last_grant = g;
        end
    end

    // Monitor: compare the presented response with the oldest queued expectation
    always begin
        @(negedge clk);
        #6;
        if (!rst && rsp_valid) begin
            check_output("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check_output("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                check_output("rsp_sum", 64'(rsp_sum), 64'(exp_q[0].sum));
                check_output("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
                check_output("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0].ovf));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        check_count = 0;
        pass_count  = 0;
        last_grant  = -1;
        model_full  = 1'b0;
        model_ptr   = 0;
        model_count = '0;
        rst         = 1'b1;
        rsp_ready   = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_cin     = '0;
        req_sub     = '0;
        clear_pend();
        for (int i = 0; i < NREQ; i++) load_random(i);
        apply_stimulus();
        #1;
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_op_count", 64'(op_count), 64'd0);
        check_output("reset_req_ready", 64'(req_ready), 64'd0);
        check_output("reset_rsp_sum", 64'(rsp_sum), 64'd0);

        // Reset while the slot is full discards the result
        do_reset();
        next_cycle();
        load_req(0, 32'd5, 32'd7, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        apply_stimulus();
        #1;
        check_output("t1_grant0", 64'(req_ready), 64'h1);
        next_cycle();
        apply_stimulus();
        #1;
        check_output("t1_full", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_output("t1_rst_valid", 64'(rsp_valid), 64'd0);
        check_output("t1_rst_count", 64'(op_count), 64'd0);
        check_output("t1_rst_ready", 64'(req_ready), 64'd0);
        next_cycle();
        rst = 1'b0;
        clear_pend();
        apply_stimulus();
        #1;
        check_output("t1_no_stale", 64'(rsp_valid), 64'd0);

        // Single add on requester 1
        do_reset();
        next_cycle();
        load_req(1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        apply_stimulus();
        next_cycle();
        apply_stimulus();
        #1;
        check_output("t2_valid", 64'(rsp_valid), 64'd1);
        check_output("t2_id", 64'(rsp_id), 64'd1);
        check_output("t2_sum", 64'(rsp_sum), 64'h0000_000C);
        check_output("t2_cout", 64'(rsp_cout), 64'd0);
        check_output("t2_ovf", 64'(rsp_ovf), 64'd0);

        // Subtract with overflow, then add with carry-out
        next_cycle();
        load_req(2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        apply_stimulus();
        next_cycle();
        apply_stimulus();
        #1;
        check_output("t3_sub_id", 64'(rsp_id), 64'd2);
        check_output("t3_sub_sum", 64'(rsp_sum), 64'h7FFF_FFFF);
        check_output("t3_sub_cout", 64'(rsp_cout), 64'd1);
        check_output("t3_sub_ovf", 64'(rsp_ovf), 64'd1);
        next_cycle();
        load_req(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        apply_stimulus();
        next_cycle();
        apply_stimulus();
        #1;
        check_output("t3_add_id", 64'(rsp_id), 64'd3);
        check_output("t3_add_sum", 64'(rsp_sum), 64'h0);
        check_output("t3_add_cout", 64'(rsp_cout), 64'd1);
        check_output("t3_add_ovf", 64'(rsp_ovf), 64'd0);

        // Round-robin with every requester continuously valid
        do_reset();
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            refill_all();
            rsp_ready = 1'b1;
            apply_stimulus();
            #1;
            check_output("t4_rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) check_output("t4_rr_id", 64'(rsp_id), 64'((k - 1) % 4));
        end

        // Backpressure holds the slot, then resumes without a bubble
        do_reset();
        next_cycle();
        refill_all();
        rsp_ready = 1'b1;
        apply_stimulus();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            refill_all();
            rsp_ready = 1'b0;
            apply_stimulus();
            #1;
            check_output("t5_bp_ready", 64'(req_ready), 64'd0);
            check_output("t5_bp_valid", 64'(rsp_valid), 64'd1);
            check_output("t5_bp_id", 64'(rsp_id), 64'd0);
        end
        next_cycle();
        rsp_ready = 1'b1;
        apply_stimulus();
        #1;
        check_output("t5_resume_grant", 64'(req_ready), 64'h2);

        // Randomized traffic with random backpressure and dropped requests
        do_reset();
        repeat (3000) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (pend_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) pend_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    load_random(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus();
        end

        // Operation counter wraps after 65536 accepts
        do_reset();
        repeat (65535) begin
            next_cycle();
            refill_all();
            rsp_ready = 1'b1;
            apply_stimulus();
        end
        next_cycle();
        refill_all();
        apply_stimulus();
        #1;
        check_output("t6_count_max", 64'(op_count), 64'hFFFF);
        next_cycle();
        refill_all();
        apply_stimulus();
        #1;
        check_output("t6_count_wrap", 64'(op_count), 64'h0);

        // Drain outstanding responses
        next_cycle();
        clear_pend();
        rsp_ready = 1'b1;
        apply_stimulus();
        repeat (3) begin
            next_cycle();
            apply_stimulus();
        end
        #8;
        check_output("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
